// File: rtl/alarm_time_counter.sv
// alarm_time_counter: 24-hour BCD HH:MM counter with minute advance and validated load (optional FAST_WATCH_EN seconds-rate mode)
module alarm_time_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_minute,
    input  logic       load_new_c,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_min,
`ifdef FAST_WATCH_EN
    input  logic       fast_watch,
    input  logic       one_second,
`endif
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min,
    output logic       load_error,
    output logic       day_wrap
);
    logic       advance;
    logic       load_ok;
    logic       hr_carry;
    logic       last_hr;
    logic       wrap;
    logic [3:0] next_ms_hr;
    logic [3:0] next_ls_hr;
    logic [3:0] next_ms_min;
    logic [3:0] next_ls_min;

`ifdef FAST_WATCH_EN
    assign advance = fast_watch ? one_second : one_minute;
`else
    assign advance = one_minute;
`endif

    // load digit validation and one-minute increment cascade
    always_comb begin
        load_ok     = (new_current_time_ms_hr <= 4'd2) && (new_current_time_ls_hr <= 4'd9) &&
                      ((new_current_time_ms_hr != 4'd2) || (new_current_time_ls_hr <= 4'd3)) &&
                      (new_current_time_ms_min <= 4'd5) && (new_current_time_ls_min <= 4'd9);
        hr_carry    = (current_time_ls_min == 4'd9) && (current_time_ms_min == 4'd5);
        last_hr     = (current_time_ms_hr == 4'd2) && (current_time_ls_hr == 4'd3);
        wrap        = hr_carry && last_hr;
        next_ls_min = (current_time_ls_min == 4'd9) ? 4'd0 : current_time_ls_min + 4'd1;
        next_ms_min = (current_time_ls_min != 4'd9) ? current_time_ms_min :
                      (current_time_ms_min == 4'd5) ? 4'd0 : current_time_ms_min + 4'd1;
        next_ls_hr  = !hr_carry ? current_time_ls_hr :
                      (last_hr || current_time_ls_hr == 4'd9) ? 4'd0 : current_time_ls_hr + 4'd1;
        next_ms_hr  = !hr_carry ? current_time_ms_hr :
                      last_hr ? 4'd0 :
                      (current_time_ls_hr == 4'd9) ? current_time_ms_hr + 4'd1 : current_time_ms_hr;
    end

    // priority: reset, then load (accepted or rejected), then advance, else hold
    always_ff @(posedge clock) begin
        if (reset) begin
            current_time_ms_hr  <= 4'd0;
            current_time_ls_hr  <= 4'd0;
            current_time_ms_min <= 4'd0;
            current_time_ls_min <= 4'd0;
            load_error          <= 1'b0;
            day_wrap            <= 1'b0;
        end else begin
            load_error <= 1'b0;
            day_wrap   <= 1'b0;
            if (load_new_c) begin
                if (load_ok) begin
                    current_time_ms_hr  <= new_current_time_ms_hr;
                    current_time_ls_hr  <= new_current_time_ls_hr;
                    current_time_ms_min <= new_current_time_ms_min;
                    current_time_ls_min <= new_current_time_ls_min;
                end else begin
                    load_error <= 1'b1;
                end
            end else if (advance) begin
                current_time_ms_hr  <= next_ms_hr;
                current_time_ls_hr  <= next_ls_hr;
                current_time_ms_min <= next_ms_min;
                current_time_ls_min <= next_ls_min;
                day_wrap            <= wrap;
            end
        end
    end
endmodule

// File: tb/tb_alarm_time_counter.sv
// tb_alarm_time_counter: table-driven vectors plus full-day and fast-watch sequences
module tb_alarm_time_counter;
    logic        clock = 1'b0;
    logic        reset, one_minute, load_new_c;
    logic [15:0] new_time;
    logic [3:0]  ms_hr, ls_hr, ms_min, ls_min;
    logic        load_error, day_wrap;
`ifdef FAST_WATCH_EN
    logic        fast_watch, one_second;
`endif
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        rst;
        logic        min;
        logic        ld;
        logic [15:0] nt;
        logic [15:0] et;
        logic        ee;
        logic        ew;
    } vec_t;
    vec_t v[26];

    always #5 clock = ~clock;

    alarm_time_counter dut (
        .clock                  (clock),
        .reset                  (reset),
        .one_minute             (one_minute),
        .load_new_c             (load_new_c),
        .new_current_time_ms_hr (new_time[15:12]),
        .new_current_time_ls_hr (new_time[11:8]),
        .new_current_time_ms_min(new_time[7:4]),
        .new_current_time_ls_min(new_time[3:0]),
`ifdef FAST_WATCH_EN
        .fast_watch             (fast_watch),
        .one_second             (one_second),
`endif
        .current_time_ms_hr     (ms_hr),
        .current_time_ls_hr     (ls_hr),
        .current_time_ms_min    (ms_min),
        .current_time_ls_min    (ls_min),
        .load_error             (load_error),
        .day_wrap               (day_wrap)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic m, input logic l, input logic [15:0] t);
        reset = r;
        one_minute = m;
        load_new_c = l;
        new_time = t;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] bcd_of(input int m);
        int h, mm;
        h = m / 60;
        mm = m % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
    endfunction

    initial begin
        int wraps;
        v[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        v[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0};
        v[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0002, 1'b0, 1'b0};
        v[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0003, 1'b0, 1'b0};
        v[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 1'b0, 1'b0};
        v[5]  = '{1'b0, 1'b0, 1'b1, 16'h0959, 16'h0959, 1'b0, 1'b0};
        v[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h1000, 1'b0, 1'b0};
        v[7]  = '{1'b0, 1'b0, 1'b1, 16'h2359, 16'h2359, 1'b0, 1'b0};
        v[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
        v[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        v[10] = '{1'b0, 1'b0, 1'b1, 16'h2400, 16'h0000, 1'b1, 1'b0};
        v[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        v[12] = '{1'b0, 1'b0, 1'b1, 16'h1960, 16'h0000, 1'b1, 1'b0};
        v[13] = '{1'b0, 1'b0, 1'b1, 16'h2A00, 16'h0000, 1'b1, 1'b0};
        v[14] = '{1'b0, 1'b0, 1'b1, 16'h2345, 16'h2345, 1'b0, 1'b0};
        v[15] = '{1'b0, 1'b1, 1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0};
        v[16] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h1235, 1'b0, 1'b0};
        v[17] = '{1'b0, 1'b0, 1'b1, 16'h1742, 16'h1742, 1'b0, 1'b0};
        v[18] = '{1'b1, 1'b0, 1'b1, 16'h0800, 16'h0000, 1'b0, 1'b0};
        v[19] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
        v[20] = '{1'b0, 1'b1, 1'b1, 16'h3000, 16'h0000, 1'b1, 1'b0};
        v[21] = '{1'b0, 1'b0, 1'b1, 16'h1959, 16'h1959, 1'b0, 1'b0};
        v[22] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h2000, 1'b0, 1'b0};
        v[23] = '{1'b0, 1'b0, 1'b1, 16'h2259, 16'h2259, 1'b0, 1'b0};
        v[24] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h2300, 1'b0, 1'b0};
        v[25] = '{1'b0, 1'b0, 1'b1, 16'h0906, 16'h0906, 1'b0, 1'b0};
`ifdef FAST_WATCH_EN
        fast_watch = 1'b0;
        one_second = 1'b0;
`endif
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 26; i++) begin
            step(v[i].rst, v[i].min, v[i].ld, v[i].nt);
            check($sformatf("vec%0d time", i), {ms_hr, ls_hr, ms_min, ls_min}, v[i].et);
            check($sformatf("vec%0d load_error", i), {15'd0, load_error}, {15'd0, v[i].ee});
            check($sformatf("vec%0d day_wrap", i), {15'd0, day_wrap}, {15'd0, v[i].ew});
        end
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        wraps = 0;
        for (int m = 1; m <= 1440; m++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0000);
            if (day_wrap) wraps++;
            check($sformatf("day min%0d", m), {ms_hr, ls_hr, ms_min, ls_min}, bcd_of(m % 1440));
        end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check("day wrap count", 16'(wraps), 16'd1);
`ifdef FAST_WATCH_EN
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        fast_watch = 1'b1;
        for (int s = 0; s < 60; s++) begin
            one_second = 1'b1;
            step(1'b0, 1'b1, 1'b0, 16'h0000);
        end
        check("fast 60s", {ms_hr, ls_hr, ms_min, ls_min}, 16'h0100);
        one_second = 1'b0;
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        check("fast min ignored", {ms_hr, ls_hr, ms_min, ls_min}, 16'h0100);
        fast_watch = 1'b0;
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        check("slow min resumes", {ms_hr, ls_hr, ms_min, ls_min}, 16'h0101);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
